// File: rtl/nibble_packer.sv
// Packs a 4-bit nibble stream LSB-first into NIBBLES-wide words behind a small output FIFO.
// Optional NIBBLE_PACKER_PARITY_EN adds a stored even-parity bit per word on out_parity.
module nibble_packer #(
    parameter int NIBBLES = 4,
    parameter int DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [3:0]             in_data,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_data,
    output logic [3:0]             out_cnt
`ifdef NIBBLE_PACKER_PARITY_EN
    ,output logic                  out_parity
`endif
);
    localparam int W  = 4 * NIBBLES;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {ASSEMBLE, FLUSH_WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_acc, w_acc_nxt, w_ins;
    logic [3:0]      r_nib_cnt, w_nib_nxt;
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [W-1:0]    r_mem_data [DEPTH];
    logic [3:0]      r_mem_cnt  [DEPTH];
    logic            w_full, w_empty, w_last, w_accept, w_pop, w_push;
    logic [W-1:0]    w_push_data;
    logic [3:0]      w_push_cnt;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_last   = (r_nib_cnt == 4'(NIBBLES - 1));
    assign w_ins    = r_acc | (W'(in_data) << {r_nib_cnt, 2'b00});
    // Stall decision uses registered state only, so a same-cycle pop cannot unblock it.
    assign in_ready = (r_state == ASSEMBLE) && !(w_full && w_last);
    assign w_accept = in_valid && in_ready;
    assign w_pop    = !w_empty && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_nib_nxt   = r_nib_cnt;
        w_push      = 1'b0;
        w_push_data = r_acc;
        w_push_cnt  = r_nib_cnt;
        case (r_state)
            ASSEMBLE: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_push      = 1'b1;
                        w_push_data = w_ins;
                        w_push_cnt  = 4'(NIBBLES);
                        w_acc_nxt   = '0;
                        w_nib_nxt   = '0;
                    end else begin
                        w_acc_nxt = w_ins;
                        w_nib_nxt = r_nib_cnt + 4'd1;
                        if (flush) w_state_nxt = FLUSH_WAIT;
                    end
                end else if (flush && (r_nib_cnt != '0)) begin
                    w_state_nxt = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_acc_nxt   = '0;
                    w_nib_nxt   = '0;
                    w_state_nxt = ASSEMBLE;
                end
            end
            default: w_state_nxt = ASSEMBLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ASSEMBLE;
            r_acc     <= '0;
            r_nib_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_nib_cnt <= w_nib_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_cnt[r_wr_ptr]  <= w_push_cnt;
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign out_cnt   = w_empty ? '0 : r_mem_cnt[r_rd_ptr];

`ifdef NIBBLE_PACKER_PARITY_EN
    logic r_mem_par [DEPTH];

    always_ff @(posedge clk) begin
        if (w_push) r_mem_par[r_wr_ptr] <= ^w_push_data;
    end

    assign out_parity = w_empty ? 1'b0 : r_mem_par[r_rd_ptr];
`endif
endmodule

// File: tb/tb_nibble_packer.sv
// Randomized and directed bench for nibble_packer against a queue-based reference model.
// Honours NIBBLE_PACKER_PARITY_EN to also check out_parity.
module tb_nibble_packer;
    localparam int NIB = 4;
    localparam int DEP = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [3:0]       in_data = '0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [4*NIB-1:0] out_data;
    logic [3:0]       out_cnt;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic             out_parity;
`endif

    nibble_packer #(.NIBBLES(NIB), .DEPTH(DEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt)
`ifdef NIBBLE_PACKER_PARITY_EN
        ,.out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pending nibbles of the open word, queued words, pending flush.
    int m_part[$];
    int m_fd[$];
    int m_fc[$];
    bit m_pend = 1'b0;
    bit m_acc  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return !m_pend && !(m_fd.size() == DEP && m_part.size() == NIB - 1);
    endfunction

    function automatic void push_part();
        int w = 0;
        foreach (m_part[k]) w += m_part[k] << (4 * k);
        m_fd.push_back(w);
        m_fc.push_back(m_part.size());
        m_part.delete();
    endfunction

    task automatic compare();
        int ed = (m_fd.size() > 0) ? m_fd[0] : 0;
        int ec = (m_fc.size() > 0) ? m_fc[0] : 0;
        check("in_ready",  32'(in_ready),  32'(exp_ready()));
        check("out_valid", 32'(out_valid), 32'(m_fd.size() > 0));
        check("out_data",  32'(out_data),  32'(ed));
        check("out_cnt",   32'(out_cnt),   32'(ec));
`ifdef NIBBLE_PACKER_PARITY_EN
        check("out_parity", 32'(out_parity), 32'($countones(ed) & 1));
`endif
    endtask

    task automatic step(input bit v, input logic [3:0] d, input bit f, input bit r);
        bit acc, was_full;
        @(negedge clk);
        compare();
        in_valid = v; in_data = d; flush = f; out_ready = r;
        acc = v && exp_ready();
        m_acc = acc;
        was_full = (m_fd.size() == DEP);
        if (r && m_fd.size() > 0) begin
            void'(m_fd.pop_front());
            void'(m_fc.pop_front());
        end
        if (m_pend) begin
            if (!was_full) begin
                push_part();
                m_pend = 1'b0;
            end
        end else if (acc) begin
            m_part.push_back(int'(d));
            if (m_part.size() == NIB) push_part();
            else if (f) m_pend = 1'b1;
        end else if (f && m_part.size() > 0) begin
            m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, r);
    endtask

    initial begin
        #23;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_cnt",   32'(out_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full word with sustained throughput
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, 1'b1);
        check("plan_word_valid", 32'(out_valid), 32'd1);
        check("plan_word_data",  32'(out_data),  32'h4321);
        check("plan_word_cnt",   32'(out_cnt),   32'd4);
`ifdef NIBBLE_PACKER_PARITY_EN
        check("plan_word_par",   32'(out_parity), 32'd1);
`endif
        idle(1'b1, 1);

        // Partial flush, then flush together with a nibble
        step(1'b1, 4'hA, 1'b0, 1'b1);
        step(1'b1, 4'hB, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        idle(1'b1, 1);
        check("flush2_data", 32'(out_data), 32'h00BA);
        check("flush2_cnt",  32'(out_cnt),  32'd2);
        idle(1'b1, 1);
        step(1'b1, 4'hC, 1'b1, 1'b1);
        idle(1'b1, 1);
        check("flush1_data", 32'(out_data), 32'h000C);
        check("flush1_cnt",  32'(out_cnt),  32'd1);
        idle(1'b1, 1);

        // Backpressure stall with full FIFO
        for (int i = 0; i <= 10; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        check("stall_ready", 32'(in_ready), 32'd0);
        check("stall_head",  32'(out_data), 32'h3210);
        step(1'b1, 4'hB, 1'b0, 1'b1);
        check("stall_unblock", 32'(in_ready), 32'd1);
        check("stall_head2",   32'(out_data), 32'h7654);
        step(1'b1, 4'hB, 1'b0, 1'b0);
        check("stall_accept_b", 32'(m_acc), 32'd1);
        idle(1'b1, 1);
        check("stall_head3", 32'(out_data), 32'hBA98);
        idle(1'b1, 2);

        // Flush held in FLUSH_WAIT by a full FIFO
        for (int i = 0; i <= 10; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        idle(1'b0, 3);
        check("fwait_ready", 32'(in_ready), 32'd0);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        idle(1'b0, 1);
        idle(1'b0, 1);
        idle(1'b1, 4);

        // Flush with nothing assembled is a no-op
        step(1'b0, 4'h0, 1'b1, 1'b1);
        idle(1'b1, 2);
        check("noop_flush_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-word with two queued words
        for (int i = 0; i < 10; i++) step(1'b1, 4'(i + 3), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data",  32'(out_data),  32'd0);
        check("async_rst_cnt",   32'(out_cnt),   32'd0);
        check("async_rst_ready", 32'(in_ready),  32'd1);
        m_part.delete(); m_fd.delete(); m_fc.delete(); m_pend = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 5; i <= 8; i++) step(1'b1, 4'(i), 1'b0, 1'b1);
        check("post_rst_word", 32'(out_data), 32'h8765);
        idle(1'b1, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 9) < 6));
        idle(1'b1, 6);
        check("final_empty", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
